// File: rtl/wrr_pkg.sv
// Shared constants, state encoding and helpers for the WRR credit/pop controller.
// Optional feature macro: WRR_CREDIT_CARRY_EN (carry leftover credit into reload).
package wrr_pkg;

    localparam int NUM_Q = 8;
    localparam int W_W   = 4;
    localparam int IDX_W = 3;

    // Saturation ceiling for a credit lane
    localparam logic [W_W-1:0] W_MAX = 4'd15;

    typedef enum logic {
        SERVE  = 1'b0,
        RELOAD = 1'b1
    } state_t;

    // Extract lane k from a packed per-queue weight vector
    function automatic logic [W_W-1:0] lane_slice(input logic [NUM_Q*W_W-1:0] vec,
                                                  input logic [IDX_W-1:0]     k);
        lane_slice = vec[int'(k)*W_W +: W_W];
    endfunction

    // One-hot decode of a queue index
    function automatic logic [NUM_Q-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(NUM_Q-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/wrr_credit_cell.sv
// Per-queue credit cell: shadow weight, current credit, decrement and reload.
// With WRR_CREDIT_CARRY_EN defined, a non-empty queue keeps its leftover credit
// at reload (saturating at W_MAX); otherwise reload overwrites the credit.
module wrr_credit_cell
    import wrr_pkg::*;
#(
    parameter logic [W_W-1:0] WEIGHT_RST = 4'd1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W_W-1:0] cfg_weight,
    input  logic           cfg_load,
    input  logic           empty,
    input  logic           reload,
    input  logic           dec,
    output logic [W_W-1:0] credit,
    output logic           eligible,
    output logic           weighted
);

    localparam logic [W_W-1:0] ZERO_W = {W_W{1'b0}};
    localparam logic [W_W-1:0] ONE_W  = {{(W_W-1){1'b0}}, 1'b1};

    logic [W_W-1:0] shadow_r;
    logic [W_W-1:0] credit_r;
    logic [W_W-1:0] credit_nxt_s;
`ifdef WRR_CREDIT_CARRY_EN
    logic [W_W:0]   carry_sum_s;
`endif

    // Shadow weight: latched on cfg_load, only consumed at the next reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= WEIGHT_RST;
        end else if (cfg_load) begin
            shadow_r <= cfg_weight;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Next credit: reload wins over decrement; decrement never goes below zero
    always_comb begin
        credit_nxt_s = credit_r;
`ifdef WRR_CREDIT_CARRY_EN
        carry_sum_s  = {1'b0, credit_r} + {1'b0, shadow_r};
`endif
        if (reload) begin
`ifdef WRR_CREDIT_CARRY_EN
            if (!empty) begin
                if (carry_sum_s > {1'b0, W_MAX}) begin
                    credit_nxt_s = W_MAX;
                end else begin
                    credit_nxt_s = carry_sum_s[W_W-1:0];
                end
            end else begin
                credit_nxt_s = shadow_r;
            end
`else
            credit_nxt_s = shadow_r;
`endif
        end else if (dec && (credit_r != ZERO_W)) begin
            credit_nxt_s = credit_r - ONE_W;
        end else begin
            credit_nxt_s = credit_r;
        end
    end

    // Credit register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_r <= ZERO_W;
        end else begin
            credit_r <= credit_nxt_s;
        end
    end

    assign credit   = credit_r;
    assign eligible = !empty && (credit_r != ZERO_W);
    // Queue has work and a non-zero weight for the next round
    assign weighted = !empty && (shadow_r != ZERO_W);

endmodule

// File: rtl/wrr_credit_ctrl.sv
// Credit and pop controller for the 8-queue WRR FIFO. Holds per-queue credits
// for the external max-weight selector, pops the selected queue and reloads
// credits at round end. Optional macro: WRR_CREDIT_CARRY_EN (see wrr_credit_cell).
module wrr_credit_ctrl
    import wrr_pkg::*;
#(
    parameter logic [W_W-1:0] WEIGHT_RST = 4'd1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_Q*W_W-1:0] cfg_weight,
    input  logic                 cfg_load,
    input  logic [NUM_Q-1:0]     empty,
    input  logic [IDX_W-1:0]     sel_idx,
    input  logic                 rd_req,
    output logic [NUM_Q*W_W-1:0] cur_weight,
    output logic [NUM_Q-1:0]     rd_en,
    output logic                 rd_valid,
    output logic [IDX_W-1:0]     rd_qid,
    output logic                 round_done
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic               reload_s;
    logic               pop_s;
    logic [NUM_Q-1:0]   dec_s;
    logic [NUM_Q-1:0]   elig_s;
    logic [NUM_Q-1:0]   weighted_s;

    logic [NUM_Q-1:0]   rd_en_r;
    logic               rd_valid_r;
    logic [IDX_W-1:0]   rd_qid_r;
    logic               round_done_r;

    genvar k;
    generate
        for (k = 0; k < NUM_Q; k++) begin : g_cell
            wrr_credit_cell #(
                .WEIGHT_RST (WEIGHT_RST)
            ) u_cell (
                .clk        (clk),
                .rst_n      (rst_n),
                .cfg_weight (cfg_weight[k*W_W +: W_W]),
                .cfg_load   (cfg_load),
                .empty      (empty[k]),
                .reload     (reload_s),
                .dec        (dec_s[k]),
                .credit     (cur_weight[k*W_W +: W_W]),
                .eligible   (elig_s[k]),
                .weighted   (weighted_s[k])
            );
        end
    endgenerate

    // State register; reset lands in RELOAD so the first action is a reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RELOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and pop/reload decisions; sel_idx is trusted only if eligible
    always_comb begin
        state_nxt_s = state_r;
        reload_s    = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            SERVE: begin
                pop_s = rd_req && elig_s[sel_idx];
                // Round ends when nothing is servable but some queue has
                // work with a non-zero weight; zero-weight work never loops
                if ((elig_s == {NUM_Q{1'b0}}) && (weighted_s != {NUM_Q{1'b0}})) begin
                    state_nxt_s = RELOAD;
                end else begin
                    state_nxt_s = SERVE;
                end
            end
            RELOAD: begin
                reload_s    = 1'b1;
                state_nxt_s = SERVE;
            end
            default: begin
                state_nxt_s = RELOAD;
            end
        endcase
    end

    assign dec_s = pop_s ? onehot(sel_idx) : {NUM_Q{1'b0}};

    // Registered pop strobe, index and round-done pulse; rd_qid holds between pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_r      <= {NUM_Q{1'b0}};
            rd_valid_r   <= 1'b0;
            rd_qid_r     <= {IDX_W{1'b0}};
            round_done_r <= 1'b0;
        end else begin
            round_done_r <= reload_s;
            if (pop_s) begin
                rd_en_r    <= onehot(sel_idx);
                rd_valid_r <= 1'b1;
                rd_qid_r   <= sel_idx;
            end else begin
                rd_en_r    <= {NUM_Q{1'b0}};
                rd_valid_r <= 1'b0;
                rd_qid_r   <= rd_qid_r;
            end
        end
    end

    assign rd_en      = rd_en_r;
    assign rd_valid   = rd_valid_r;
    assign rd_qid     = rd_qid_r;
    assign round_done = round_done_r;

endmodule

// File: doc/wrr_credit_ctrl.md
Name: wrr_credit_ctrl

Overview:
- Credit and pop controller for the 8-queue WRR FIFO. It sits on the other side of the combinational max-weight selector.
- Holds per-queue current weights (credits) and drives them to the selector. It consumes the selected queue index, issues one-hot pop strobes to the queue FIFOs, and decrements the served queue's credit.
- Reloads all credits from configured weights at the end of each round.

Parameters:
- NUM_Q, 8, number of queues (fixed 8 for this revision).
- W_W, 4, credit/weight width in bits.
- WEIGHT_RST, 4'd1, per-queue configured weight after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- cfg_weight  in  32  packed configured weights; queue k at bits [4k+3:4k]
- cfg_load  in  1  latch cfg_weight into the shadow register
- empty  in  8  per-queue FIFO empty flags
- sel_idx  in  3  selected queue index returned by the max-weight selector
- rd_req  in  1  downstream ready to accept one word this cycle
- cur_weight  out  32  packed current credits, same layout as cfg_weight, fed to the selector
- rd_en  out  8  one-hot FIFO pop strobe, registered
- rd_valid  out  1  registered; high when rd_en is non-zero
- rd_qid  out  3  registered index of the queue popped
- round_done  out  1  one-cycle pulse when a reload occurs

Behaviour:
- Reset values:
  - cur_weight = 0
  - shadow = WEIGHT_RST in every lane
  - rd_en = 0, rd_valid = 0, rd_qid = 0, round_done = 0
  - state = RELOAD
- States are SERVE and RELOAD.
- cfg_load, any state: shadow <= cfg_weight at the clock edge. The new value takes effect at the next reload only. If cfg_load and a reload occur at the same edge, the reload uses the old shadow.
- eligible(k) = !empty[k] && cur_weight[k] != 0.
- RELOAD, one cycle:
  - cur_weight <= shadow (overwrite, no accumulation).
  - round_done <= 1, rd_en <= 0.
  - Next state = SERVE.
- SERVE, pop condition: rd_req && eligible(sel_idx).
  - Next edge: rd_en <= 1 << sel_idx, rd_valid <= 1, rd_qid <= sel_idx.
  - Same edge: cur_weight[sel_idx] decrements by 1.
  - Pop latency is 1 cycle from rd_req. Back-to-back pops every cycle are allowed.
- SERVE, no pop: rd_en <= 0, rd_valid <= 0. Credits are unchanged.
- Guard on sel_idx: the selector defaults to index 7 when no lane wins. A pop is never issued unless eligible(sel_idx) holds, so the guard covers both empty and zero-credit lanes.
- Round end: no k is eligible, some queue is non-empty, and some non-empty queue has a non-zero shadow weight.
  - Next state = RELOAD. This is independent of rd_req.
- All queues empty: stay in SERVE with no pop and no reload. Leftover credits are held.
- Zero configured weight:
  - Shadow weight 0 disables that queue.
  - If every non-empty queue has shadow weight 0, stay in SERVE with no reload loop and no pop.
- Credits are never decremented below 0. The width stays W_W with no wrap.
- A queue that goes empty mid-round keeps its remaining credit until the next reload overwrites it.
- rst_n low mid-operation: all outputs return to reset values immediately (asynchronous).
  - A pending pop is dropped.
  - First action after release is RELOAD.

Optional Feature:
- Macro: WRR_CREDIT_CARRY_EN.
- Defined: at RELOAD, cur_weight[k] <= min(cur_weight[k] + shadow[k], 15) for queues that were non-empty at the reload edge. Empty queues get plain shadow[k].
- Undefined: plain overwrite, as described above.

Decomposition:
- Package wrr_pkg holds:
  - NUM_Q and W_W constants
  - state enum {SERVE, RELOAD}
  - lane slice helper / constant W_MAX = 15
  - one-hot decode function
- Sub-module wrr_credit_cell, one per queue, holds:
  - shadow and credit registers
  - load, decrement, saturation and optional carry logic
  - eligible output
- The top level holds the FSM, the pop register and the output packing.

Test Plan:
- Reset, weights all 1, all queues non-empty, rd_req held high:
  - After RELOAD, 8 pops follow with rd_qid tracking sel_idx.
  - Then a reload with a round_done pulse. Repeat.
- cfg_weight lane0 = 3, others = 1, all non-empty:
  - Per round: 3 pops of queue 0, 1 pop of each other queue, 10 pops in total.
  - Credit lane0 reads 3, 2, 1, 0.
- empty = 8'hFF, rd_req high:
  - rd_en stays 0, no round_done, credits held.
- Queue 2 goes empty with credit 2 left, others exhausted:
  - Reload fires. Lane2 becomes the shadow value.
  - With WRR_CREDIT_CARRY_EN and lane2 non-empty at the edge: 2 + shadow, saturating at 15 (e.g. 14 + 3 gives 15).
- Force sel_idx = 7 with empty[7] = 1 or credit7 = 0:
  - No pop issued.
- rst_n pulsed low while rd_en = 8'h04:
  - rd_en clears without waiting for a clock.
  - First cycle after release is RELOAD with round_done = 1.
